// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command sequencer: frame FSM state encoding,
// frame constants (header and opcodes), address/data widths and the byte
// parity helper.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP     = 3'd1,
    ST_ADDR_H = 3'd2,
    ST_ADDR_L = 3'd3,
    ST_DATA_H = 3'd4,
    ST_DATA_L = 3'd5,
    ST_SUM    = 3'd6,
    ST_ISSUE  = 3'd7
  } state_t;

  localparam logic [7:0] HDR   = 8'h55;
  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // A byte is good when the XOR over its 8 data bits and its parity bit equals
  // the selected parity sense (0 = even, 1 = odd).
  function automatic logic parity_ok(input logic [7:0] data,
                                     input logic       par,
                                     input logic       odd);
    return ((^data) ^ par) == odd;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// -----------------------------------------------------------------------------
// uart_frame_timer
// Inter-byte gap counter for frame reception. Counts cycles while enabled and
// flags expiry once TIMEOUT_CYCLES-1 has been reached without a clear.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_clr      clear the count (a byte arrived); overrides expiry
//   i_en       count enable (frame body in progress); count held at 0 when low
//   o_expired  combinational: gap limit reached this cycle
// -----------------------------------------------------------------------------
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_en) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // A byte in the same cycle wins over the timeout.
  assign o_expired = i_en && !i_clr && (r_count == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Command sequencer between the UART byte receiver and the SDRAM request port.
// Checks byte parity, assembles 0x55-headed command frames protected by an XOR
// checksum, and issues one 16-bit read or write request per good frame.
//
// Frames:  write 55 01 AH AL DH DL SUM    read 55 02 AH AL SUM
//          SUM = XOR of every byte after the header.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rx_data/rx_parity      received byte + parity bit, valid while rx_en=1
//   rx_en                  one-cycle strobe per received byte
//   cmd_req/cmd_ack        SDRAM request handshake
//   cmd_we/addr/wdata      request payload, stable while cmd_req=1
//   err_parity             one-cycle pulse per bad-parity byte
//   err_frame              one-cycle pulse per dropped frame
//   busy                   state is not IDLE
//   dbg_state              current FSM state encoding
//
// Handshake: cmd_req rises with the payload and stays high with the payload
// frozen until a cycle in which cmd_ack=1 is sampled (the first cycle of
// cmd_req included); cmd_req drops on the following cycle. cmd_ack is
// ignored whenever cmd_req=0.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned SYS_CLK        = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000,
  parameter bit          PARITY_ODD     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_parity,
  input  logic              rx_en,
  output logic              cmd_req,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ack,
  output logic              err_parity,
  output logic              err_frame,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // SYS_CLK is informational; a zero clock or zero timeout degrades to the
  // shortest meaningful gap limit instead of an unusable counter.
  localparam int unsigned TIMEOUT_EFF =
    (SYS_CLK > 0 && TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;

  state_t              r_state, w_state_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [7:0]          r_sum, w_sum_nxt;
  logic                r_cmd_req;
  logic                r_cmd_we, w_cmd_we_nxt;
  logic [ADDR_W-1:0]   r_cmd_addr, w_cmd_addr_nxt;
  logic [DATA_W-1:0]   r_cmd_wdata, w_cmd_wdata_nxt;
  logic                r_err_parity, w_err_parity_nxt;
  logic                r_err_frame, w_err_frame_nxt;

  logic                w_par_ok;
  logic [7:0]          w_sum_upd;
  logic                w_in_body;
  logic                w_expired;

  assign w_par_ok  = parity_ok(rx_data, rx_parity, PARITY_ODD);
  assign w_sum_upd = r_sum ^ rx_data;
  assign w_in_body = (r_state != ST_IDLE) && (r_state != ST_ISSUE);

  uart_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_EFF)
  ) u_timer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (rx_en),
    .i_en      (w_in_body),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_sum        <= '0;
      r_cmd_req    <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_sum        <= w_sum_nxt;
      r_cmd_req    <= (w_state_nxt == ST_ISSUE);
      r_cmd_we     <= w_cmd_we_nxt;
      r_cmd_addr   <= w_cmd_addr_nxt;
      r_cmd_wdata  <= w_cmd_wdata_nxt;
      r_err_parity <= w_err_parity_nxt;
      r_err_frame  <= w_err_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_sum_nxt        = r_sum;
    w_cmd_we_nxt     = r_cmd_we;
    w_cmd_addr_nxt   = r_cmd_addr;
    w_cmd_wdata_nxt  = r_cmd_wdata;
    w_err_parity_nxt = 1'b0;
    w_err_frame_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (rx_en) begin
          if (!w_par_ok) begin
            w_err_parity_nxt = 1'b1;
          end else if (rx_data == HDR) begin
            w_state_nxt = ST_OP;
            w_sum_nxt   = '0;
          end
        end
      end

      ST_ISSUE: begin
        // The request stays pending; a stray byte only costs that byte.
        if (rx_en) begin
          w_err_frame_nxt = 1'b1;
        end
        if (cmd_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        // Frame body: OP .. SUM
        if (rx_en) begin
          if (!w_par_ok) begin
            w_err_parity_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_sum_nxt = w_sum_upd;
            unique case (r_state)
              ST_OP: begin
                if (rx_data == OP_WR) begin
                  w_we_nxt    = 1'b1;
                  w_state_nxt = ST_ADDR_H;
                end else if (rx_data == OP_RD) begin
                  w_we_nxt    = 1'b0;
                  w_state_nxt = ST_ADDR_H;
                end else begin
                  w_err_frame_nxt = 1'b1;
                  w_state_nxt     = ST_IDLE;
                end
              end
              ST_ADDR_H: begin
                w_addr_nxt  = {rx_data, r_addr[7:0]};
                w_state_nxt = ST_ADDR_L;
              end
              ST_ADDR_L: begin
                w_addr_nxt  = {r_addr[15:8], rx_data};
                w_state_nxt = r_we ? ST_DATA_H : ST_SUM;
              end
              ST_DATA_H: begin
                w_data_nxt  = {rx_data, r_data[7:0]};
                w_state_nxt = ST_DATA_L;
              end
              ST_DATA_L: begin
                w_data_nxt  = {r_data[15:8], rx_data};
                w_state_nxt = ST_SUM;
              end
              ST_SUM: begin
                // The checksum byte is compared against the sum of the bytes
                // before it, not including itself.
                if (rx_data == r_sum) begin
                  w_cmd_we_nxt    = r_we;
                  w_cmd_addr_nxt  = r_addr;
                  w_cmd_wdata_nxt = r_we ? r_data : '0;
                  w_state_nxt     = ST_ISSUE;
                end else begin
                  w_err_frame_nxt = 1'b1;
                  w_state_nxt     = ST_IDLE;
                end
              end
              default: ;
            endcase
          end
        end else if (w_expired) begin
          w_err_frame_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
    endcase
  end

  assign cmd_req    = r_cmd_req;
  assign cmd_we     = r_cmd_we;
  assign cmd_addr   = r_cmd_addr;
  assign cmd_wdata  = r_cmd_wdata;
  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Scoreboard bench for uart_cmd_ctrl. Stimulus tasks build whole frames,
// decide the expected outcome from the frame rules (good command, parity
// error, dropped frame, or nothing) and push it into exp_q; a monitor on the
// falling edge pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int unsigned TO   = 100;
  localparam bit          PODD = 1'b0;

  localparam logic [1:0] K_CMD = 2'd1;
  localparam logic [1:0] K_PAR = 2'd2;
  localparam logic [1:0] K_FRM = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_parity = 1'b0;
  logic        rx_en = 1'b0;
  logic        cmd_ack = 1'b0;
  logic        cmd_req;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        err_parity;
  logic        err_frame;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Event word: {kind[1:0], we, addr[15:0], wdata[15:0]}
  logic [34:0] exp_q[$];

  logic [7:0] fr[7];
  int         fr_len;
  logic       prev_req = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .SYS_CLK        (50_000_000),
    .TIMEOUT_CYCLES (TO),
    .PARITY_ODD     (PODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_parity  (rx_parity),
    .rx_en      (rx_en),
    .cmd_req    (cmd_req),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_ack    (cmd_ack),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic observe(input string name, input logic [34:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s actual=%h required=none at %0t", name, got, $time);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (err_parity) observe("err_parity", {K_PAR, 33'h0});
    if (err_frame)  observe("err_frame",  {K_FRM, 33'h0});
    if (cmd_req && !prev_req) observe("cmd", {K_CMD, cmd_we, cmd_addr, cmd_wdata});
    prev_req = cmd_req;
  end

  // ---------------- model / expectation helpers ----------------
  function automatic logic [34:0] ev_cmd(input logic we, input logic [15:0] a, input logic [15:0] d);
    return {K_CMD, we, a, (we ? d : 16'h0000)};
  endfunction

  task automatic push(input logic [34:0] ev);
    exp_q.push_back(ev);
  endtask

  // Frame built straight from the wire format; checksum covers bytes 1..len-2.
  task automatic build(input logic we, input logic [15:0] a, input logic [15:0] d);
    logic [7:0] s;
    fr[0] = 8'h55;
    fr[1] = we ? 8'h01 : 8'h02;
    fr[2] = a[15:8];
    fr[3] = a[7:0];
    if (we) begin
      fr[4]  = d[15:8];
      fr[5]  = d[7:0];
      fr_len = 7;
    end else begin
      fr_len = 5;
    end
    s = 8'h00;
    for (int i = 1; i < fr_len - 1; i++) s = s ^ fr[i];
    fr[fr_len-1] = s;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad);
    rx_data   = d;
    rx_parity = (^d) ^ PODD ^ bad;
    rx_en     = 1'b1;
    tick(1);
    rx_en     = 1'b0;
  endtask

  task automatic send_frame(input int n, input int bad_idx, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(fr[i], (i == bad_idx));
      if (i < n - 1) tick($urandom_range(0, max_gap));
    end
  endtask

  // Wait (bounded) for cmd_req, optionally inject a byte during ISSUE, then ack.
  task automatic ack_request(input int delay, input logic poke);
    for (int i = 0; i < 20 && !cmd_req; i++) tick(1);
    if (!cmd_req) begin
      checks++;
      failures++;
      $display("FAIL cmd_req_wait actual=0 required=1 at %0t", $time);
      return;
    end
    if (poke) begin
      push({K_FRM, 33'h0});
      send_byte(8'($urandom), 1'b0);
      check("req_held_after_byte", {34'h0, cmd_req}, 35'h1);
    end
    tick(delay);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    check("req_low_after_ack", {34'h0, cmd_req}, 35'h0);
    check("idle_after_ack", {34'h0, busy}, 35'h0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {cmd_req, cmd_we, cmd_addr, err_parity, err_frame, busy},  35'h0);
    check({name, "_wdata_state"}, {16'h0, cmd_wdata, dbg_state}, 35'h0);
  endtask

  task automatic random_frame();
    logic        we;
    logic [15:0] a, d;
    logic [7:0]  b;
    int          kind, p;
    we = 1'($urandom_range(0, 1));
    a  = 16'($urandom);
    d  = 16'($urandom);
    build(we, a, d);
    kind = $urandom_range(0, 6);
    case (kind)
      0, 1: begin
        push(ev_cmd(we, a, d));
        send_frame(fr_len, -1, 4);
        ack_request($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      2: begin
        fr[fr_len-1] = fr[fr_len-1] ^ 8'($urandom_range(1, 255));
        push({K_FRM, 33'h0});
        send_frame(fr_len, -1, 4);
      end
      3: begin
        fr[1] = 8'($urandom_range(3, 255));
        push({K_FRM, 33'h0});
        send_frame(2, -1, 4);
      end
      4: begin
        p = $urandom_range(0, fr_len - 1);
        push({K_PAR, 33'h0});
        send_frame(p + 1, p, 4);
      end
      5: begin
        p = $urandom_range(1, fr_len - 1);
        push({K_FRM, 33'h0});
        send_frame(p, -1, 4);
        tick(TO + 3);
      end
      default: begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h56;
        if ($urandom_range(0, 1) == 1) begin
          push({K_PAR, 33'h0});
          send_byte(b, 1'b1);
        end else begin
          send_byte(b, 1'b0);
        end
      end
    endcase
    tick($urandom_range(1, 3));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    check_all_zero("post_reset_idle");

    // Write frame, ack after 3 cycles, then back-to-back read with same-cycle ack.
    build(1'b1, 16'h1234, 16'hABCD);
    check("wr_sum_byte", {27'h0, fr[6]}, {27'h0, 8'h41});
    push(ev_cmd(1'b1, 16'h1234, 16'hABCD));
    send_frame(7, -1, 0);
    ack_request(3, 1'b0);
    build(1'b0, 16'h0010, 16'h0000);
    check("rd_sum_byte", {27'h0, fr[4]}, {27'h0, 8'h12});
    push(ev_cmd(1'b0, 16'h0010, 16'h0000));
    send_frame(5, -1, 0);
    ack_request(0, 1'b0);
    tick(2);

    // Bad checksum and bad opcode.
    build(1'b1, 16'h1234, 16'hABCD);
    fr[6] = 8'h40;
    push({K_FRM, 33'h0});
    send_frame(7, -1, 2);
    tick(2);
    fr[1] = 8'h07;
    push({K_FRM, 33'h0});
    send_frame(2, -1, 0);
    tick(1);
    check("idle_after_bad_op", {34'h0, busy}, 35'h0);

    // Parity error on the AL byte, then a normal frame.
    build(1'b1, 16'h1234, 16'hABCD);
    push({K_PAR, 33'h0});
    send_frame(4, 3, 1);
    tick(1);
    check("idle_after_parity", {34'h0, busy}, 35'h0);
    push(ev_cmd(1'b1, 16'h1234, 16'hABCD));
    send_frame(7, -1, 1);
    ack_request(1, 1'b0);

    // Timeout: err_frame on the 100th idle cycle after the last byte.
    build(1'b1, 16'h1234, 16'hABCD);
    push({K_FRM, 33'h0});
    send_frame(3, -1, 0);
    n = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      tick(1);
      if (err_frame) begin
        n = i;
        break;
      end
    end
    check("timeout_cycle", 35'(n), 35'(TO));
    check("timeout_busy", {34'h0, busy}, 35'h0);
    tick(2);

    // Reset in DATA_L (with a byte arriving the same cycle).
    build(1'b1, 16'h1234, 16'hABCD);
    send_frame(5, -1, 0);
    check("in_data_l", {32'h0, dbg_state}, 35'h5);
    rst       = 1'b1;
    rx_data   = fr[5];
    rx_parity = (^fr[5]) ^ PODD;
    rx_en     = 1'b1;
    tick(1);
    rx_en = 1'b0;
    check_all_zero("reset_mid_frame");
    rst = 1'b0;
    tick(3);

    // Reset while a request is pending.
    push(ev_cmd(1'b1, 16'h1234, 16'hABCD));
    send_frame(7, -1, 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    check_all_zero("reset_mid_issue");
    rst = 1'b0;
    tick(2);

    // Byte during ISSUE, and ack while idle is ignored.
    build(1'b0, 16'hBEEF, 16'h0000);
    push(ev_cmd(1'b0, 16'hBEEF, 16'h0000));
    send_frame(5, -1, 2);
    ack_request(2, 1'b1);
    cmd_ack = 1'b1;
    tick(2);
    cmd_ack = 1'b0;
    check("ack_idle_ignored", {33'h0, cmd_req, busy}, 35'h0);

    // Randomized frames.
    repeat (60) random_frame();

    tick(5);
    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL missing_event actual=none required=%h", exp_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
